memory_stage: RTL

//  MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of execute.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/memory_stage_if.sv | 23 ++
 rtl/memory_stage_load_formatter.sv | 30 +++
 rtl/memory_stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: aluop codes, MEM-stage FSM state and byte-lane helpers.
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'b010011;
    localparam logic [5:0] OP_SW  = 6'b010100;
    localparam logic [5:0] OP_LB  = 6'b010101;
    localparam logic [5:0] OP_SB  = 6'b010111;
    localparam logic [5:0] OP_LBU = 6'b011000;
    localparam logic [5:0] OP_NOP = 6'b100001;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_LB) ||
               (op == OP_SB) || (op == OP_LBU);
    endfunction

    // Big-endian lanes: byte offset 0 lives in bits 31:24, i.e. be[3].
    function automatic logic [3:0] lane_be(input logic [5:0] op, input logic [1:0] off);
        if ((op == OP_LW) || (op == OP_SW))
            return 4'b1111;
        return 4'b1000 >> off;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/ack bus between the MEM stage (master) and data memory (slave).
interface memory_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        dm_be;
    logic [31:0]       dm_wdata;
    logic              dm_ack;
    logic [31:0]       dm_rdata;
    logic              dm_err;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata, dm_err,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata, dm_err,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/memory_stage_load_formatter.sv
// Combinational load alignment: picks the addressed big-endian byte and extends it for LB/LBU.
module load_formatter
    import mips_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [5:0]  i_aluop,
    output logic [31:0] o_data
);
    logic [7:0] w_byte;

    always_comb begin
        w_byte = 8'h00;
        case (i_off)
            2'd0: w_byte = i_rdata[31:24];
            2'd1: w_byte = i_rdata[23:16];
            2'd2: w_byte = i_rdata[15:8];
            2'd3: w_byte = i_rdata[7:0];
            default: w_byte = 8'h00;
        endcase
    end

    always_comb begin
        o_data = i_rdata;
        if (i_aluop == OP_LB)
            o_data = {{24{w_byte[7]}}, w_byte};
        else if (i_aluop == OP_LBU)
            o_data = {24'h000000, w_byte};
    end
endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: EX/MEM latch, req/ack data-memory FSM with timeout, writeback and MX bypass.
// Optional MEM_ALIGN_CHECK_EN: misaligned LW/SW are retired without a request and flagged.
module memory_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ex_valid,
    input  logic [31:0]           ex_alu_out,
    input  logic [31:0]           ex_rb_out,
    input  logic [5:0]            ex_aluop,
    input  logic                  ex_dmwe,
    input  logic                  ex_rwe,
    input  logic                  ex_rwd,
    input  logic [4:0]            ex_wreg,
    output logic                  stall,
    memory_stage_if.master        dm,
    output logic                  wb_valid,
    output logic                  wb_rwe,
    output logic [4:0]            wb_reg,
    output logic [31:0]           wb_data,
    output logic [31:0]           mx_bypass,
    output logic [4:0]            mx_reg,
    output logic                  mx_valid,
    output logic                  misalign
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic             r_vld, r_dmwe, r_rwe, r_rwd;
    logic [5:0]       r_op;
    logic [31:0]      r_alu, r_rb;
    logic [4:0]       r_wreg;
    mem_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_wait;
    logic             r_wb_valid, r_wb_rwe, r_err, r_misal;
    logic [4:0]       r_wb_reg;
    logic [31:0]      r_wb_data;
    logic             w_misal, w_go, w_acc, w_timeout;
    logic [31:0]      w_load;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misal = r_vld && ((r_op == OP_LW) || (r_op == OP_SW)) && (r_alu[1:0] != 2'b00);
`else
    assign w_misal = 1'b0;
`endif

    assign w_go      = r_vld && is_mem_op(r_op) && !w_misal;
    assign w_acc     = (r_state == ST_ACCESS);
    assign w_timeout = w_acc && !dm.dm_ack && (r_wait == CNT_W'(MAX_WAIT - 1));

    // Stall covers the IDLE cycle that launches the access and every ACCESS cycle until it ends.
    assign stall = ((r_state == ST_IDLE) && w_go) || (w_acc && !dm.dm_ack && !w_timeout);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vld  <= 1'b0;
            r_op   <= OP_NOP;
            r_alu  <= '0;
            r_rb   <= '0;
            r_dmwe <= 1'b0;
            r_rwe  <= 1'b0;
            r_rwd  <= 1'b0;
            r_wreg <= '0;
        end else if (!stall) begin
            r_vld  <= ex_valid;
            r_op   <= ex_valid ? ex_aluop : OP_NOP;
            r_alu  <= ex_alu_out;
            r_rb   <= ex_rb_out;
            r_dmwe <= ex_dmwe;
            r_rwe  <= ex_rwe;
            r_rwd  <= ex_rwd;
            r_wreg <= ex_wreg;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= (w_acc && w_state_nxt == ST_ACCESS) ? r_wait + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_go) w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (dm.dm_ack || w_timeout) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    load_formatter u_fmt (
        .i_rdata (dm.dm_rdata),
        .i_off   (r_alu[1:0]),
        .i_aluop (r_op),
        .o_data  (w_load)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wb_valid <= 1'b0;
            r_wb_rwe   <= 1'b0;
            r_wb_reg   <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
            r_misal    <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_rwe   <= 1'b0;
            r_err      <= 1'b0;
            r_misal    <= 1'b0;
            if (w_acc) begin
                if (dm.dm_ack) begin
                    r_wb_valid <= 1'b1;
                    r_wb_rwe   <= r_rwe && !r_dmwe;
                    r_wb_reg   <= r_wreg;
                    r_wb_data  <= r_rwd ? w_load : r_alu;
                end else if (w_timeout) begin
                    r_wb_valid <= 1'b1;
                    r_wb_reg   <= r_wreg;
                    r_wb_data  <= r_alu;
                    r_err      <= 1'b1;
                end
            end else if (r_vld && !w_go) begin
                // Non-memory ops and rejected misaligned accesses retire straight from the latch.
                r_wb_valid <= 1'b1;
                r_wb_rwe   <= r_rwe && !w_misal;
                r_wb_reg   <= r_wreg;
                r_wb_data  <= r_alu;
                r_misal    <= w_misal;
            end
        end
    end

    assign dm.dm_req   = w_acc;
    assign dm.dm_we    = w_acc && r_dmwe;
    assign dm.dm_addr  = w_acc ? {r_alu[ADDR_W-1:2], 2'b00} : '0;
    assign dm.dm_be    = w_acc ? lane_be(r_op, r_alu[1:0]) : 4'b0000;
    assign dm.dm_wdata = !w_acc ? 32'h0 : (r_op == OP_SB) ? {4{r_rb[7:0]}} : r_rb;
    assign dm.dm_err   = r_err;

    assign wb_valid  = r_wb_valid;
    assign wb_rwe    = r_wb_rwe;
    assign wb_reg    = r_wb_reg;
    assign wb_data   = r_wb_data;
    assign mx_bypass = r_alu;
    assign mx_reg    = r_wreg;
    // Loads carry rwd=1, so they never feed the MX bypass.
    assign mx_valid  = r_vld && r_rwe && !r_rwd;
    assign misalign  = r_misal;
endmodule
